l7_match_collector: RTL and testbench



---
 rtl/l7_match_collector_if.sv | 23 ++
 rtl/l7_match_collector.sv | 218 +++++++++++++++++++++
 tb/tb_l7_match_collector.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/l7_match_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : l7_match_collector_if
// Description : Record stream between the match collector and its consumer.
//               Master drives valid and the record fields, slave drives ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface l7_match_collector_if #(
  parameter int OFF_W = 16
) ();
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic [OFF_W-1:0] m_offset;
  logic [3:0]       m_hit;
  logic [3:0]       m_suffix;

  modport master (output m_valid, m_last, m_offset, m_hit, m_suffix,
                  input  m_ready);
  modport slave  (input  m_valid, m_last, m_offset, m_hit, m_suffix,
                  output m_ready);
endinterface
`default_nettype wire

// File: rtl/l7_match_collector.sv
`default_nettype none
// ============================================================================
// Module      : l7_match_collector
// Description : Aligns byte framing with the Cuckoo compare outputs, emits one
//               record per matching byte plus a per-packet summary record, and
//               buffers records in a first-word-fall-through FIFO.
//               Optional feature macro: L7_NOCASE_EN (nocase hits/suffixes).
// Revision    : 1.0 - initial release
// ============================================================================
module l7_match_collector #(
  parameter int PIPE_LAT   = 4,
  parameter int OFF_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 enable_i,
  input  wire logic                 sop_i,
  input  wire logic                 eop_i,
  input  wire logic [1:0]           compare_out_i,
  input  wire logic [1:0]           suffix_i,
  input  wire logic [1:0]           compare_out_nocase_i,
  input  wire logic [1:0]           suffix_nocase_i,
  l7_match_collector_if.master      m_if,
  output logic      [7:0]           ovf_cnt_o,
  output logic                      proto_err_o
);

  localparam int                AW        = $clog2(FIFO_DEPTH);
  localparam int                REC_W     = 1 + OFF_W + 8;
  localparam logic [AW:0]       C_DEPTH   = (AW+1)'(FIFO_DEPTH);
  localparam logic [OFF_W-1:0]  C_OFF_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_PKT  = 2'd1,
    SUMMARY = 2'd2
  } state_t;

  // ---------------------------------------------------------------- signals
  logic [2:0]       line_q [PIPE_LAT];
  logic             v_dly, sop_dly, eop_dly;
  logic [1:0]       nc_cmp, nc_sfx;
  logic [3:0]       hit_bits, sfx_bits;

  state_t           state_q, state_d;
  logic             push_sum, take_byte, push_hit;
  logic             perr_d, perr_q;

  logic [OFF_W-1:0] off_q, off_d, byte_off;
  logic [7:0]       mcnt_q, mcnt_d, cnt_base;

  logic [REC_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, rd_q, wr_nxt;
  logic [AW:0]      fcnt_q, free;
  logic [REC_W-1:0] rec_hit, rec_sum, rec0, rec1, head;
  logic             want0, want1, acc0, acc1, pop, valid;
  logic [1:0]       n_acc, drops;
  logic [7:0]       ovf_q;
  logic [8:0]       ovf_sum;

  // Nocase compare bits only take part when the feature is compiled in.
`ifdef L7_NOCASE_EN
  assign nc_cmp = compare_out_nocase_i;
  assign nc_sfx = suffix_nocase_i;
`else
  logic unused_nocase;
  assign nc_cmp        = 2'b00;
  assign nc_sfx        = 2'b00;
  assign unused_nocase = ^{compare_out_nocase_i, suffix_nocase_i};
`endif

  assign hit_bits = {nc_cmp, compare_out_i};
  assign sfx_bits = {nc_sfx, suffix_i};

  // Delay line carrying {enable, sop, eop} so framing lines up with compares.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_LAT; i++) line_q[i] <= 3'b000;
    end else begin
      line_q[0] <= {enable_i, sop_i, eop_i};
      for (int i = 1; i < PIPE_LAT; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign v_dly   = line_q[PIPE_LAT-1][2];
  assign sop_dly = line_q[PIPE_LAT-1][1];
  assign eop_dly = line_q[PIPE_LAT-1][0];

  // Packet framing state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Framing decode: which bytes belong to a packet, summary push, errors.
  always_comb begin
    state_d   = state_q;
    push_sum  = 1'b0;
    take_byte = 1'b0;
    perr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (v_dly) begin
          if (sop_dly) begin
            take_byte = 1'b1;
            state_d   = eop_dly ? SUMMARY : IN_PKT;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      IN_PKT: begin
        if (v_dly) begin
          take_byte = 1'b1;
          perr_d    = sop_dly;
          if (eop_dly) state_d = SUMMARY;
        end
      end
      SUMMARY: begin
        // Summary goes out this cycle even if a new packet starts alongside.
        push_sum = 1'b1;
        state_d  = IDLE;
        if (v_dly) begin
          if (sop_dly) begin
            take_byte = 1'b1;
            state_d   = eop_dly ? SUMMARY : IN_PKT;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_hit = take_byte & (|hit_bits);

  // Offset of the current byte is the counter before its own increment.
  assign byte_off = sop_dly ? '0 : off_q;
  assign cnt_base = sop_dly ? 8'd0 : mcnt_q;

  // Next values for the offset counter and the per-packet match count.
  always_comb begin
    off_d  = off_q;
    mcnt_d = mcnt_q;
    if (v_dly) begin
      off_d = (byte_off == C_OFF_MAX) ? C_OFF_MAX : byte_off + OFF_W'(1);
    end
    if (take_byte) begin
      mcnt_d = (push_hit && cnt_base != 8'hFF) ? cnt_base + 8'd1 : cnt_base;
    end
  end

  // Offset counter, match counter and the registered error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      off_q  <= '0;
      mcnt_q <= 8'd0;
      perr_q <= 1'b0;
    end else begin
      off_q  <= off_d;
      mcnt_q <= mcnt_d;
      perr_q <= perr_d;
    end
  end

  // Up to two records per cycle: the pending summary first, then a hit.
  assign rec_hit = {1'b0, byte_off, hit_bits, sfx_bits};
  assign rec_sum = {1'b1, OFF_W'(mcnt_q), 8'h00};
  assign want0   = push_sum | push_hit;
  assign want1   = push_sum & push_hit;
  assign rec0    = push_sum ? rec_sum : rec_hit;
  assign rec1    = rec_hit;

  assign valid   = (fcnt_q != '0);
  assign pop     = valid & m_if.m_ready;
  assign free    = C_DEPTH - fcnt_q + {{AW{1'b0}}, pop};
  assign acc0    = want0 && (free != '0);
  assign acc1    = want1 && (free > (AW+1)'(1));
  assign n_acc   = {1'b0, acc0} + {1'b0, acc1};
  assign drops   = {1'b0, want0 & ~acc0} + {1'b0, want1 & ~acc1};
  assign ovf_sum = {1'b0, ovf_q} + {7'd0, drops};
  assign wr_nxt  = wr_q + AW'(1);

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      ovf_q  <= 8'd0;
    end else begin
      wr_q   <= wr_q + AW'(n_acc);
      rd_q   <= rd_q + AW'(pop);
      fcnt_q <= fcnt_q + (AW+1)'(n_acc) - (AW+1)'(pop);
      ovf_q  <= ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    end
  end

  // Record storage; contents are don't-care until pointed at by rd_q.
  always_ff @(posedge clk) begin
    if (acc0) mem_q[wr_q]   <= rec0;
    if (acc1) mem_q[wr_nxt] <= rec1;
  end

  // Head record is forced to zero while the FIFO is empty.
  assign head            = valid ? mem_q[rd_q] : '0;
  assign m_if.m_valid    = valid;
  assign m_if.m_last     = head[REC_W-1];
  assign m_if.m_offset   = head[REC_W-2 -: OFF_W];
  assign m_if.m_hit      = head[7:4];
  assign m_if.m_suffix   = head[3:0];
  assign ovf_cnt_o       = ovf_q;
  assign proto_err_o     = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_l7_match_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_l7_match_collector
// Description : Randomized and directed stimulus for l7_match_collector,
//               checked every cycle against a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l7_match_collector;

  localparam int L  = 4;
  localparam int OW = 16;
  localparam int D  = 8;

  typedef struct packed {
    bit       en, sop, eop;
    bit [1:0] c, s, cn, sn;
  } byte_t;

  typedef struct packed {
    bit          last;
    bit [OW-1:0] off;
    bit [3:0]    hit;
    bit [3:0]    sfx;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable_i = 1'b0, sop_i = 1'b0, eop_i = 1'b0;
  logic [1:0] compare_out_i = 2'b00, suffix_i = 2'b00;
  logic [1:0] compare_out_nocase_i = 2'b00, suffix_nocase_i = 2'b00;
  logic [7:0] ovf_cnt_o;
  logic       proto_err_o;

  l7_match_collector_if #(.OFF_W(OW)) mif ();

  l7_match_collector #(.PIPE_LAT(L), .OFF_W(OW), .FIFO_DEPTH(D)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable_i             (enable_i),
    .sop_i                (sop_i),
    .eop_i                (eop_i),
    .compare_out_i        (compare_out_i),
    .suffix_i             (suffix_i),
    .compare_out_nocase_i (compare_out_nocase_i),
    .suffix_nocase_i      (suffix_nocase_i),
    .m_if                 (mif),
    .ovf_cnt_o            (ovf_cnt_o),
    .proto_err_o          (proto_err_o)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------- reference model
  byte_t hist[$];      // bytes in flight towards the compare stage
  rec_t  mq[$];        // expected FIFO contents, head first
  bit    m_in_pkt, m_sum_due, m_perr;
  int    m_off, m_cnt, m_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void push_rec(input rec_t r);
    if (mq.size() < D) mq.push_back(r);
    else if (m_ovf < 255) m_ovf++;
  endfunction

  // One clock edge of behaviour: consumer pop, pending summary, then the byte.
  function automatic void model_apply(input byte_t d, input bit rdy);
    bit [3:0] hb, sb;
    rec_t     r;
`ifdef L7_NOCASE_EN
    hb = {d.cn, d.c};
    sb = {d.sn, d.s};
`else
    hb = {2'b00, d.c};
    sb = {2'b00, d.s};
`endif
    if (rdy && mq.size() > 0) mq.delete(0);
    m_perr = 1'b0;
    if (m_sum_due) begin
      r = '{last: 1'b1, off: OW'(m_cnt), hit: 4'h0, sfx: 4'h0};
      push_rec(r);
      m_sum_due = 1'b0;
    end
    if (d.en) begin
      if (d.sop) begin
        if (m_in_pkt) m_perr = 1'b1;
        m_in_pkt = 1'b1;
        m_off    = 0;
        m_cnt    = 0;
      end else if (!m_in_pkt) begin
        m_perr = 1'b1;
      end
      if (m_in_pkt) begin
        if (hb != 4'h0) begin
          r = '{last: 1'b0, off: OW'(m_off), hit: hb, sfx: sb};
          push_rec(r);
          if (m_cnt < 255) m_cnt++;
        end
        if (m_off < (1 << OW) - 1) m_off++;
        if (d.eop) begin
          m_in_pkt  = 1'b0;
          m_sum_due = 1'b1;
        end
      end
    end
  endfunction

  task automatic check_all();
    rec_t h;
    h = (mq.size() > 0) ? mq[0] : '0;
    chk("m_valid",   mif.m_valid,  mq.size() != 0);
    chk("m_last",    mif.m_last,   h.last);
    chk("m_offset",  mif.m_offset, h.off);
    chk("m_hit",     mif.m_hit,    h.hit);
    chk("m_suffix",  mif.m_suffix, h.sfx);
    chk("ovf_cnt",   ovf_cnt_o,    m_ovf);
    chk("proto_err", proto_err_o,  m_perr);
  endtask

  // Drive one byte; compare inputs come from the byte issued L cycles ago.
  task automatic step(input byte_t b, input bit rdy);
    byte_t d;
    hist.push_back(b);
    d = hist.pop_front();
    enable_i             = b.en;
    sop_i                = b.sop;
    eop_i                = b.eop;
    compare_out_i        = d.c;
    suffix_i             = d.s;
    compare_out_nocase_i = d.cn;
    suffix_nocase_i      = d.sn;
    mif.m_ready          = rdy;
    model_apply(d, rdy);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input int cyc);
    rst         = 1'b0;
    enable_i    = 1'b0;
    sop_i       = 1'b0;
    eop_i       = 1'b0;
    mif.m_ready = 1'b0;
    repeat (cyc) @(posedge clk);
    @(negedge clk);
    mq.delete();
    hist.delete();
    for (int i = 0; i < L; i++) hist.push_back('0);
    m_in_pkt  = 1'b0;
    m_sum_due = 1'b0;
    m_perr    = 1'b0;
    m_off     = 0;
    m_cnt     = 0;
    m_ovf     = 0;
    check_all();
    rst = 1'b1;
  endtask

  function automatic byte_t mk(input bit en, input bit sop, input bit eop,
                               input bit [1:0] c, input bit [1:0] cn);
    byte_t b;
    b     = '0;
    b.en  = en;
    b.sop = sop;
    b.eop = eop;
    b.c   = c;
    b.s   = c;
    b.cn  = cn;
    b.sn  = 2'b10;
    return b;
  endfunction

  initial begin
    byte_t b;
    int    pkt_rem;
    bit    last_eop;
    bit    rdy;
    int    mode;

    mif.m_ready = 1'b0;
    do_reset(3);

    // 10-byte packet with a case hit on byte 3.
    for (int i = 0; i < 10; i++) step(mk(1'b1, i == 0, i == 9, (i == 3) ? 2'b01 : 2'b00, 2'b00), 1'b1);
    for (int i = 0; i < L + 3; i++) step('0, 1'b1);

    // Single-byte packet without a hit, then a nocase-only hit byte.
    step(mk(1'b1, 1'b1, 1'b1, 2'b00, 2'b00), 1'b1);
    for (int i = 0; i < L + 3; i++) step('0, 1'b1);
    step(mk(1'b1, 1'b1, 1'b0, 2'b00, 2'b11), 1'b1);
    step(mk(1'b1, 1'b0, 1'b1, 2'b00, 2'b00), 1'b1);
    for (int i = 0; i < L + 3; i++) step('0, 1'b1);

    // Restart mid-packet at byte 5, hit two bytes later.
    for (int i = 0; i < 10; i++) step(mk(1'b1, i == 0 || i == 5, i == 9, (i == 7) ? 2'b10 : 2'b00, 2'b00), 1'b1);
    for (int i = 0; i < L + 3; i++) step('0, 1'b1);

    // Twelve hits with the consumer stalled: FIFO fills, excess dropped.
    do_reset(1);
    for (int i = 0; i < 12; i++) step(mk(1'b1, i == 0, i == 11, 2'b01, 2'b00), 1'b0);
    for (int i = 0; i < L + 2; i++) step('0, 1'b0);
    chk("burst_ovf", ovf_cnt_o, 8'd5);
    for (int i = 0; i < 12; i++) step('0, 1'b1);

    // Reset with three records queued and three hit bytes still in flight.
    do_reset(1);
    for (int i = 0; i < 6; i++) step(mk(1'b1, i == 0, 1'b0, 2'b11, 2'b00), 1'b0);
    step('0, 1'b0);
    do_reset(1);
    chk("rst_valid", mif.m_valid, 1'b0);
    chk("rst_ovf",   ovf_cnt_o,   8'd0);
    for (int i = 0; i < L + 4; i++) step('0, 1'b1);

    // Randomized traffic with varying consumer back-pressure.
    pkt_rem  = 0;
    last_eop = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      mode  = (n / 250) % 3;
      b     = '0;
      b.c   = 2'($urandom);
      b.s   = 2'($urandom);
      b.cn  = 2'($urandom);
      b.sn  = 2'($urandom);
      b.en  = ($urandom_range(0, 3) != 0);
      if (b.en) begin
        if ($urandom_range(0, 2) != 0) begin
          b.c  = 2'b00;
          b.cn = 2'b00;
        end
        if (pkt_rem == 0) begin
          if (!last_eop && $urandom_range(0, 15) == 0) begin
            b.sop = 1'b0;
          end else begin
            b.sop   = 1'b1;
            pkt_rem = $urandom_range(1, 16);
          end
        end else if ($urandom_range(0, 39) == 0) begin
          b.sop   = 1'b1;
          pkt_rem = $urandom_range(1, 16);
        end
        if (pkt_rem > 0) begin
          b.eop   = (pkt_rem == 1);
          pkt_rem = pkt_rem - 1;
        end
      end
      last_eop = b.en && b.eop;
      case (mode)
        0:       rdy = ($urandom_range(0, 9) != 0);
        1:       rdy = ($urandom_range(0, 3) == 0);
        default: rdy = ($urandom_range(0, 19) == 0);
      endcase
      step(b, rdy);
    end
    for (int i = 0; i < L + D + 4; i++) step('0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
